// File: rtl/hbus_dly_cal.sv
// hbus_dly_cal: HyperBus read-path latency calibration engine.
// Fires probe pulses into a loopback path, times each echo, and
// derives the delay-line code that brings total latency to TARGET.
// Ports: clk, rst (async, active-high), start, echo in;
//        probe, busy, done, err, delay[N-1:0], min_lat, max_lat out.
module hbus_dly_cal #(
  parameter int N           = 3,
  parameter int TARGET      = 8,
  parameter int TIMEOUT     = 31,
  parameter int TRIALS_LOG2 = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         echo,
  output logic         probe,
  output logic         busy,
  output logic         done,
  output logic         err,
  output logic [N-1:0] delay,
  output logic [7:0]   min_lat,
  output logic [7:0]   max_lat
);

  typedef enum logic [2:0] {
    S_IDLE, S_SEND, S_WAIT, S_GAP, S_EVAL, S_FIN
  } state_t;

  localparam logic [7:0] TO = 8'(TIMEOUT);
  localparam logic [8:0] TGT = 9'(TARGET);
  localparam logic [8:0] CMAX = 9'((1 << N) - 1);
  localparam logic [TRIALS_LOG2:0] NTRIAL =
    (TRIALS_LOG2+1)'(1 << TRIALS_LOG2);

  state_t state, state_n;
  logic [7:0] cnt, cnt_n;
  logic [7:0] mn, mn_n;
  logic [7:0] mx, mx_n;
  logic [TRIALS_LOG2:0] trial, trial_n;
  logic to, to_n;

  logic [8:0] spread, margin;
  logic ev_err;
  logic [N-1:0] ev_code;

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    mn_n    = mn;
    mx_n    = mx;
    trial_n = trial;
    to_n    = to;
    unique case (state)
      S_IDLE: begin
        if (start) begin
          state_n = S_SEND;
          mn_n    = 8'hff;
          mx_n    = 8'h00;
          trial_n = '0;
          to_n    = 1'b0;
        end
      end
      S_SEND: begin
        state_n = S_WAIT;
        cnt_n   = 8'd1;
      end
      S_WAIT: begin
        // An echo on the last allowed cycle still counts as a hit.
        if (echo) begin
          if (cnt < mn) mn_n = cnt;
          if (cnt > mx) mx_n = cnt;
          cnt_n   = 8'd1;
          state_n = S_GAP;
        end else if (cnt == TO) begin
          to_n    = 1'b1;
          state_n = S_EVAL;
        end else begin
          cnt_n = cnt + 8'd1;
        end
      end
      S_GAP: begin
        // Hold off the next probe until the echo line is quiet.
        if (!echo) begin
          trial_n = trial + 1'b1;
          if (trial_n == NTRIAL) state_n = S_EVAL;
          else                   state_n = S_SEND;
        end else if (cnt == TO) begin
          to_n    = 1'b1;
          state_n = S_EVAL;
        end else begin
          cnt_n = cnt + 8'd1;
        end
      end
      S_EVAL:  state_n = S_FIN;
      S_FIN:   state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  // 9-bit arithmetic so a negative result shows up in bit 8.
  assign spread = {1'b0, mx} - {1'b0, mn};
  assign margin = TGT - {1'b0, mx};

  always_comb begin
    ev_err  = 1'b0;
    ev_code = '0;
    if (to) begin
      ev_err = 1'b1;
    end else if (spread[8] || spread > 9'd1) begin
      ev_err = 1'b1;
    end else if (margin[8]) begin
      ev_err = 1'b1;
    end else if (margin > CMAX) begin
      ev_err  = 1'b1;
      ev_code = '1;
    end else begin
      ev_code = margin[N-1:0];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= S_IDLE;
      cnt     <= '0;
      mn      <= '0;
      mx      <= '0;
      trial   <= '0;
      to      <= 1'b0;
      probe   <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      err     <= 1'b0;
      delay   <= '0;
      min_lat <= '0;
      max_lat <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      mn    <= mn_n;
      mx    <= mx_n;
      trial <= trial_n;
      to    <= to_n;
      probe <= (state_n == S_SEND);
      busy  <= (state_n == S_SEND) || (state_n == S_WAIT) ||
               (state_n == S_GAP)  || (state_n == S_EVAL);
      done  <= (state_n == S_FIN);
      if (state == S_IDLE && start) err <= 1'b0;
      if (state == S_EVAL) begin
        err     <= ev_err;
        delay   <= ev_code;
        min_lat <= mn;
        max_lat <= mx;
      end
    end
  end

endmodule

// File: tb/tb_hbus_dly_cal.sv
// tb_hbus_dly_cal: scoreboard bench for hbus_dly_cal.
// Two instances (TARGET 8 and 12) share one modelled loopback path.
module tb_hbus_dly_cal;

  localparam int TO = 31;
  localparam int NT = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic echo = 1'b0;

  logic       probe_a, busy_a, done_a, err_a;
  logic [2:0] delay_a;
  logic [7:0] mn_a, mx_a;
  logic       probe_b, busy_b, done_b, err_b;
  logic [2:0] delay_b;
  logic [7:0] mn_b, mx_b;

  hbus_dly_cal #(.N(3), .TARGET(8), .TIMEOUT(TO), .TRIALS_LOG2(2)) u_a (
    .clk(clk), .rst(rst), .start(start), .probe(probe_a), .echo(echo),
    .busy(busy_a), .done(done_a), .err(err_a), .delay(delay_a),
    .min_lat(mn_a), .max_lat(mx_a)
  );

  hbus_dly_cal #(.N(3), .TARGET(12), .TIMEOUT(TO), .TRIALS_LOG2(2)) u_b (
    .clk(clk), .rst(rst), .start(start), .probe(probe_b), .echo(echo),
    .busy(busy_b), .done(done_b), .err(err_b), .delay(delay_b),
    .min_lat(mn_b), .max_lat(mx_b)
  );

  always #5 clk = ~clk;

  typedef struct {
    int dly; int err; int mn; int mx;
    int dur; int probes; int t0;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];
  int nchk = 0;
  int nfail = 0;
  int cyc = 0;

  // Loopback description: mode 0 = delay line, 1 = tied 0, 2 = tied 1.
  int mode = 0;
  int wid = 1;
  int lat[NT];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int req);
    nchk++;
    if (act != req) begin
      nfail++;
      $display("FAIL %s: got %0d required %0d", name, act, req);
    end
  endtask

  // Reference: walk the trials as the loopback would present them.
  function automatic exp_t model(input int tgt);
    exp_t e;
    int mn = 255;
    int mx = 0;
    bit to = 0;
    int d = 0;
    int np = 0;
    if (mode == 1) begin
      to = 1; d = 1 + TO; np = 1;
    end else if (mode == 2) begin
      to = 1; mn = 1; mx = 1; d = 2 + TO; np = 1;
    end else begin
      for (int k = 0; k < NT && !to; k++) begin
        np++;
        if (lat[k] > TO) begin
          to = 1; d += 1 + TO;
        end else begin
          if (lat[k] < mn) mn = lat[k];
          if (lat[k] > mx) mx = lat[k];
          d += 1 + lat[k] + wid;
        end
      end
    end
    e.dur = d + 2;
    e.probes = np;
    e.mn = mn;
    e.mx = mx;
    e.t0 = 0;
    if (to || mx - mn > 1 || mx > tgt) begin
      e.err = 1; e.dly = 0;
    end else if (tgt - mx > 7) begin
      e.err = 1; e.dly = 7;
    end else begin
      e.err = 0; e.dly = tgt - mx;
    end
    return e;
  endfunction

  // Issue one calibration; called just after a falling edge.
  task automatic run_cal(input bit pulse);
    exp_t e;
    int cd = 0;
    int wl = 0;
    int k = 0;
    bit seen = 0;
    e = model(8);  e.t0 = cyc + 1; qa.push_back(e);
    e = model(12); e.t0 = cyc + 1; qb.push_back(e);
    start = 1'b1;
    for (int c = 0; c < 400 && !seen; c++) begin
      @(negedge clk);
      if (mode == 1) begin
        echo = 1'b0;
      end else if (mode == 2) begin
        echo = 1'b1;
      end else begin
        if (cd > 0) begin
          cd--;
          if (cd == 0) wl = wid;
        end
        echo = (wl > 0);
        if (wl > 0) wl--;
        if (probe_a && k < NT) begin
          cd = lat[k];
          k++;
        end
      end
      if (done_a) seen = 1;
      start = pulse && !seen && c[0];
    end
    chk("done_within_budget", int'(seen), 1);
    start = 1'b0;
    echo = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic set_lat(input int a, input int b, input int c, input int d);
    lat[0] = a; lat[1] = b; lat[2] = c; lat[3] = d;
  endtask

  // Monitor: pops the scoreboard on every done pulse.
  initial begin : monitor
    exp_t e;
    bit pa = 0;
    bit pb = 0;
    int npa = 0;
    int npb = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        chk("rst_outs_a", int'({probe_a, busy_a, done_a, err_a,
                                delay_a, mn_a, mx_a}), 0);
        chk("rst_outs_b", int'({probe_b, busy_b, done_b, err_b,
                                delay_b, mn_b, mx_b}), 0);
        npa = 0; npb = 0; pa = 0; pb = 0;
      end else begin
        if (probe_a) begin
          chk("probe_single_a", int'(pa), 0);
          chk("probe_echo_low", int'(echo), 0);
          npa++;
        end
        if (probe_b) npb++;
        pa = probe_a;
        pb = probe_b;
        if (done_a) begin
          chk("queue_a_nonempty", int'(qa.size() > 0), 1);
          if (qa.size() > 0) begin
            e = qa.pop_front();
            chk("delay_a", int'(delay_a), e.dly);
            chk("err_a", int'(err_a), e.err);
            chk("min_lat_a", int'(mn_a), e.mn);
            chk("max_lat_a", int'(mx_a), e.mx);
            chk("duration_a", cyc - e.t0 + 1, e.dur);
            chk("probes_a", npa, e.probes);
            chk("busy_low_a", int'(busy_a), 0);
          end
          npa = 0;
        end
        if (done_b) begin
          chk("queue_b_nonempty", int'(qb.size() > 0), 1);
          if (qb.size() > 0) begin
            e = qb.pop_front();
            chk("delay_b", int'(delay_b), e.dly);
            chk("err_b", int'(err_b), e.err);
            chk("min_lat_b", int'(mn_b), e.mn);
            chk("max_lat_b", int'(mx_b), e.mx);
            chk("probes_b", npb, e.probes);
          end
          npb = 0;
        end
      end
    end
  end

  initial begin : stim
    int base;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    mode = 0; wid = 1;
    set_lat(3, 3, 3, 3);    run_cal(0);
    set_lat(3, 4, 3, 4);    run_cal(0);
    set_lat(3, 5, 3, 5);    run_cal(0);
    mode = 1;               run_cal(0);
    mode = 2;               run_cal(0);
    mode = 0;
    set_lat(10, 10, 10, 10); run_cal(0);
    set_lat(1, 1, 1, 1);    run_cal(0);
    set_lat(TO, TO, TO, TO); run_cal(0);

    // Abort a calibration in WAIT; nothing is expected from it.
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("rst_async_a", int'({probe_a, busy_a, done_a, err_a,
                             delay_a, mn_a, mx_a}), 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    set_lat(3, 3, 3, 3);    run_cal(0);

    set_lat(3, 3, 3, 3);    run_cal(1);
    wid = 3;
    set_lat(2, 3, 2, 3);    run_cal(1);

    for (int i = 0; i < 20; i++) begin
      mode = 0;
      wid = $urandom_range(1, 3);
      base = $urandom_range(1, 12);
      for (int k = 0; k < NT; k++) begin
        lat[k] = base + $urandom_range(0, 1);
        if ($urandom_range(0, 3) == 0) lat[k] = $urandom_range(1, 14);
        if ($urandom_range(0, 15) == 0) lat[k] = 200;
      end
      run_cal($urandom_range(0, 1) == 1);
    end

    repeat (5) @(negedge clk);
    chk("queue_a_drained", qa.size(), 0);
    chk("queue_b_drained", qb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             nchk, nfail);
    $finish;
  end

endmodule

// File: doc/hbus_dly_cal.md
# hbus_dly_cal

Read-path latency calibration engine for the HyperBus controller. It fires single-cycle probe pulses into an external loopback path and counts cycles until each echo returns. After a fixed number of trials it checks that the measured latencies are consistent and computes the `delay` code for the companion tapped delay line. That code makes the total read-capture latency equal a fixed `TARGET`. It runs once after reset, or on demand, before normal bus traffic starts.

## Interface
- `N`, 3: width of the delay code; the maximum code is 2^N-1.
- `TARGET`, 8: required total latency in cycles, loopback latency plus delay code.
- `TIMEOUT`, 31: maximum cycles to wait for an echo, or for echo to go low again; must be 1..255.
- `TRIALS_LOG2`, 2: number of probe trials is 2^TRIALS_LOG2.

Ports:
- `clk` in 1: single clock; everything is synchronous to its rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `start` in 1: request a calibration; sampled only in IDLE.
- `probe` out 1: probe pulse to the loopback path, registered.
- `echo` in 1: returned probe, already synchronised to `clk`.
- `busy` out 1: high from the cycle after `start` is accepted until `done`.
- `done` out 1: one-cycle pulse; `delay`, `err`, `min_lat` and `max_lat` are valid from this cycle.
- `err` out 1: calibration failed; held until the next accepted `start`.
- `delay` out N: computed delay code; held until the next `done`.
- `min_lat` out 8: smallest measured latency.
- `max_lat` out 8: largest measured latency.

## Operation
- States: IDLE, SEND, WAIT, GAP, EVAL, FIN.
- IDLE: `start`=1 moves to SEND. On that transition:
  - min register := 255, max register := 0, trial counter := 0;
  - timeout flag and spread flag cleared; `err` cleared.
- SEND (1 cycle): `probe`=1, latency counter := 1, next state WAIT.
- WAIT: each cycle, `echo` is sampled.
  - `echo`=1: latency := counter. Update min/max, unsigned compare on 8 bits. Go to GAP.
  - `echo`=0 with counter==TIMEOUT: set timeout flag, go to EVAL.
  - Otherwise the counter increments.
- GAP: wait for `echo`=0.
  - `echo`=0: increment the trial counter. If trials done == 2^TRIALS_LOG2, go to EVAL; else go to SEND.
  - Echo stuck high for TIMEOUT cycles: set timeout flag, go to EVAL.
- EVAL (1 cycle), in priority order:
  - timeout → err=1, code 0;
  - max−min > 1 → err=1, code 0;
  - max > TARGET → err=1, code 0;
  - TARGET−max > 2^N−1 → err=1, code 2^N−1;
  - otherwise err=0, code = TARGET−max.
  - All arithmetic is 9-bit unsigned with the sign checked; no wrap-around.
- FIN (1 cycle): register `delay`/`err`/`min_lat`/`max_lat` from EVAL, pulse `done`, return to IDLE.
- On timeout, `min_lat`/`max_lat` report the values accumulated so far (255/0 if no echo ever arrived).
- `start` in any state other than IDLE is ignored; there is no queuing.
- `rst` at any time forces IDLE immediately. Reset values:
  - `probe`=0, `busy`=0, `done`=0, `err`=0;
  - `delay`=0, `min_lat`=0, `max_lat`=0;
  - all counters 0.

## Timing
- `start` sampled high at edge 0 → SEND during cycle 1: `probe`=1 and `busy`=1.
- Echo sampled high at cycle 1+L → latency L. L=1 means the echo is seen in the first WAIT cycle.
- Each trial costs 1 (SEND) + L (WAIT) + G cycles. G ≥ 1 is the number of GAP cycles.
- Last GAP exit → EVAL next cycle → FIN next cycle. `done`=1 in FIN; `busy` falls in the same cycle.
- Total duration with constant L and clean echo (G=1): 2^TRIALS_LOG2·(L+2)+2 cycles from `start` to `done`.
- No-echo abort: `done` occurs TIMEOUT+3 cycles after `start`.
- `probe` is never high for more than one consecutive cycle.
- `probe` is never high while `echo` is high in GAP.

## Test plan
- Loopback delays `probe` by 3 cycles, N=3, TARGET=8, 4 trials: `min_lat`=`max_lat`=3, `delay`=5, `err`=0, `done` 22 cycles after `start`.
- Latency alternates 3/4: `min_lat`=3, `max_lat`=4, `delay`=4, `err`=0. Alternating 3/5: `err`=1, `delay`=0.
- `echo` tied 0, TIMEOUT=31: `err`=1, `delay`=0, `min_lat`=255, `max_lat`=0, `done` exactly 34 cycles after `start`. `echo` tied 1: `err`=1 via GAP timeout.
- Latency 10 with TARGET=8: `err`=1, `delay`=0. Latency 1 with TARGET=12: `err`=1, `delay`=7 (range saturation).
- Assert `rst` mid-WAIT: all outputs 0 within the reset. The next `start` gives a normal calibration (`delay`=5 at latency 3).
- Pulse `start` repeatedly while `busy`=1: exactly one `done` occurs, and the probe count equals 2^TRIALS_LOG2.
